// File: rtl/adc_frame_scheduler.sv
// Periodic AD7606 trigger plus framed byte streamer (A5, count, enabled samples, optional XOR sum).
// Define FRAME_CHECKSUM_EN to append the checksum byte to every frame.
module adc_frame_scheduler #(
  parameter int CLK_FRE     = 50,
  parameter int SEND_FRE    = 2,
  parameter int TICK_CYCLES = CLK_FRE * 1000000 / SEND_FRE,
  parameter int TIMEOUT     = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ch_mask,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [7:0][15:0] adc_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TRIG = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HDR  = 3'd3;
  localparam logic [2:0] ST_CNT  = 3'd4;
  localparam logic [2:0] ST_DATA = 3'd5;
`ifdef FRAME_CHECKSUM_EN
  localparam logic [2:0] ST_SUM  = 3'd6;
  localparam logic [2:0] ST_LAST = ST_SUM;
`else
  localparam logic [2:0] ST_LAST = ST_IDLE;
`endif

  logic [2:0]    state_reg, state_next;
  logic [TW-1:0] timer_reg;
  logic [WW-1:0] wait_reg;
  logic [15:0]   sample_reg [8];
  logic [7:0]    mask_reg;
  logic [7:0]    remain_reg;
  logic          half_reg;
  logic          tick;
  logic          xfer;
  logic          capture;
  logic          wait_expired;
  logic          last_ch;
  logic [2:0]    cur_ch;
  logic [3:0]    pop_cnt;

  assign tick         = (timer_reg == TICK_LAST);
  assign xfer         = tx_valid && tx_ready;
  assign capture      = (state_reg == ST_WAIT) && adc_done;
  assign wait_expired = (wait_reg == WAIT_LAST);
  assign last_ch      = ((remain_reg & (remain_reg - 8'd1)) == 8'd0);

  // Free-running send timer; never disturbed by the FSM.
  always_ff @(posedge clk) begin
    if (rst)       timer_reg <= '0;
    else if (tick) timer_reg <= '0;
    else           timer_reg <= timer_reg + TW'(1);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (tick) state_next = ST_TRIG;
      ST_TRIG: state_next = ST_WAIT;
      ST_WAIT: begin
        if (adc_done)          state_next = ST_HDR;
        else if (wait_expired) state_next = ST_IDLE;
      end
      ST_HDR:  if (xfer) state_next = ST_CNT;
      ST_CNT:  if (xfer) state_next = (mask_reg != 8'd0) ? ST_DATA : ST_LAST;
      ST_DATA: if (xfer && half_reg && last_ch) state_next = ST_LAST;
`ifdef FRAME_CHECKSUM_EN
      ST_SUM:  if (xfer) state_next = ST_IDLE;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      wait_reg   <= '0;
      mask_reg   <= '0;
      remain_reg <= '0;
      half_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= (state_reg == ST_WAIT) ? wait_reg + WW'(1) : '0;
      if (capture) begin
        mask_reg   <= ch_mask;
        remain_reg <= ch_mask;
        half_reg   <= 1'b0;
      end else if ((state_reg == ST_DATA) && xfer) begin
        // Retire a channel once its low byte has gone out.
        half_reg <= ~half_reg;
        if (half_reg) remain_reg <= remain_reg & (remain_reg - 8'd1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sample
      always_ff @(posedge clk) begin
        if (rst)          sample_reg[gi] <= '0;
        else if (capture) sample_reg[gi] <= adc_data[gi];
      end
    end
  endgenerate

  always_comb begin
    cur_ch = '0;
    for (int i = 7; i >= 0; i--) begin
      if (remain_reg[i]) cur_ch = 3'(i);
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      pop_cnt = pop_cnt + 4'(mask_reg[i]);
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] chk_reg;

  // XOR of every byte after the header, accumulated as bytes are accepted.
  always_ff @(posedge clk) begin
    if (rst)          chk_reg <= '0;
    else if (capture) chk_reg <= '0;
    else if (xfer && ((state_reg == ST_CNT) || (state_reg == ST_DATA)))
      chk_reg <= chk_reg ^ tx_data;
  end
`endif

  always_comb begin
    tx_data = 8'h00;
    case (state_reg)
      ST_HDR:  tx_data = 8'hA5;
      ST_CNT:  tx_data = {4'h0, pop_cnt};
      ST_DATA: tx_data = half_reg ? sample_reg[cur_ch][7:0] : sample_reg[cur_ch][15:8];
`ifdef FRAME_CHECKSUM_EN
      ST_SUM:  tx_data = chk_reg;
`endif
      default: tx_data = 8'h00;
    endcase
  end

`ifdef FRAME_CHECKSUM_EN
  assign tx_valid = (state_reg == ST_HDR) || (state_reg == ST_CNT) ||
                    (state_reg == ST_DATA) || (state_reg == ST_SUM);
`else
  assign tx_valid = (state_reg == ST_HDR) || (state_reg == ST_CNT) ||
                    (state_reg == ST_DATA);
`endif

  assign adc_start   = (state_reg == ST_TRIG);
  assign busy        = (state_reg != ST_IDLE);
  assign overrun     = tick && (state_reg != ST_IDLE);
  assign timeout_err = (state_reg == ST_WAIT) && !adc_done && wait_expired;

endmodule
